// File: rtl/control_seq_pkg.sv
// Shared definitions for the microprogram sequencer: sequencing opcodes,
// FSM state encoding and datapath control field positions.
package control_seq_pkg;

  localparam int DEF_LOG_MEMSIZE    = 4;
  localparam int DEF_NUM_D_CTRLBITS = 5;
  localparam int DEF_NUM_C_CTRLBITS = 2;

  typedef enum logic [1:0] {
    SEQ_NEXT = 2'b00,
    SEQ_JMP  = 2'b01,
    SEQ_BRC  = 2'b10,
    SEQ_HALT = 2'b11
  } seq_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // pd_ctrl bit positions: {op[1:0], sw, wb, wa}
  localparam int PD_WA    = 0;
  localparam int PD_WB    = 1;
  localparam int PD_SW    = 2;
  localparam int PD_OP_LO = 3;
  localparam int PD_OP_HI = 4;

endpackage

// File: rtl/control_seq_if.sv
// Program-load port and datapath control link between the sequencer and its
// surroundings.
interface control_seq_if #(
  parameter int L = 4,
  parameter int D = 5,
  parameter int C = 2
) ();

  localparam int W = L + D + C;

  // Load handshake: a word is written on a rising clk edge where
  // ld_valid && ld_ready; ld_ready depends only on sequencer state, never on
  // ld_valid, and a request held while ld_ready=0 simply waits.
  logic         ld_valid;
  logic         ld_ready;
  logic [L-1:0] ld_addr;
  logic [W-1:0] ld_data;

  logic         cres;
  logic [D-1:0] pd_ctrl;

  modport master (
    output ld_valid,
    output ld_addr,
    output ld_data,
    output cres,
    input  ld_ready,
    input  pd_ctrl
  );

  modport slave (
    input  ld_valid,
    input  ld_addr,
    input  ld_data,
    input  cres,
    output ld_ready,
    output pd_ctrl
  );

endinterface

// File: rtl/control_seq_ctrl_mem.sv
// Control store: 2**L words, synchronous write port, asynchronous read port.
// Contents are deliberately not reset so a program survives a sequencer reset.
module ctrl_mem #(
  parameter int L = 4,
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [L-1:0] waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic [L-1:0] raddr_i,
  output logic [W-1:0] rdata_o
);

  logic [W-1:0] mem_q [2**L];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/control_seq.sv
// Microprogram sequencer: steps a pc through the control store, drives the
// datapath control bits of the current word and branches on cres.
module control_seq
  import control_seq_pkg::*;
#(
  parameter int P_LOG_MEMSIZE    = DEF_LOG_MEMSIZE,
  parameter int P_NUM_D_CTRLBITS = DEF_NUM_D_CTRLBITS,
  parameter int P_NUM_C_CTRLBITS = DEF_NUM_C_CTRLBITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  control_seq_if.slave             bus,
  output logic [P_LOG_MEMSIZE-1:0] pc,
  output logic                     busy,
  output logic                     halted,
  output state_e                   dbg_state
);

  localparam int L = P_LOG_MEMSIZE;
  localparam int D = P_NUM_D_CTRLBITS;
  localparam int C = P_NUM_C_CTRLBITS;
  localparam int W = L + D + C;

  state_e       state_q, state_d;
  logic [L-1:0] pc_q, pc_d;
  logic [L-1:0] pc_inc;
  logic [W-1:0] word;
  logic [L-1:0] target;
  seq_op_e      seq_op;
  logic         ld_ready;
  logic         ld_fire;
  logic         mem_we;
  logic [D-1:0] pd_ctrl;

  assign ld_ready = (state_q != ST_RUN);
  assign ld_fire  = bus.ld_valid & ld_ready;
  // Reset wins over a same-cycle load request.
  assign mem_we   = ld_fire & rst;

  ctrl_mem #(
    .L(L),
    .W(W)
  ) u_ctrl_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (bus.ld_addr),
    .wdata_i (bus.ld_data),
    .raddr_i (pc_q),
    .rdata_o (word)
  );

  assign target = word[W-1:W-L];
  assign seq_op = seq_op_e'(word[D+C-1:D]);
  assign pc_inc = pc_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        // A load in the same cycle consumes the start request.
        if (start && !ld_fire) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN: begin
        case (seq_op)
          SEQ_NEXT: pc_d = pc_inc;
          SEQ_JMP:  pc_d = target;
          SEQ_BRC:  pc_d = bus.cres ? target : pc_inc;
          SEQ_HALT: state_d = ST_HALT;
          default:  pc_d = pc_inc;
        endcase
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_comb begin
    pd_ctrl = '0;
    if (state_q == ST_RUN) begin
      pd_ctrl[PD_WA]             = word[PD_WA];
      pd_ctrl[PD_WB]             = word[PD_WB];
      pd_ctrl[PD_SW]             = word[PD_SW];
      pd_ctrl[PD_OP_HI:PD_OP_LO] = word[PD_OP_HI:PD_OP_LO];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.ld_ready = ld_ready;
  assign bus.pd_ctrl  = pd_ctrl;
  assign pc           = pc_q;
  assign busy         = (state_q == ST_RUN);
  assign halted       = (state_q == ST_HALT);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq: a vector table walks load, straight-line,
// branch and wrap programs; hand sequences cover reset mid-run and restart.
module tb_control_seq;
  import control_seq_pkg::*;

  localparam int L = 4;
  localparam int D = 5;
  localparam int C = 2;
  localparam int W = L + D + C;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [L-1:0] pc;
  logic         busy;
  logic         halted;
  state_e       dbg_state;

  control_seq_if #(.L(L), .D(D), .C(C)) bus ();

  control_seq #(
    .P_LOG_MEMSIZE    (L),
    .P_NUM_D_CTRLBITS (D),
    .P_NUM_C_CTRLBITS (C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus.slave),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    string        tag;
    bit           start;
    bit           cres;
    bit           ldv;
    logic [L-1:0] lda;
    logic [W-1:0] ldd;
    logic [L-1:0] e_pc;
    logic [D-1:0] e_pd;
    bit           e_busy;
    bit           e_halted;
    bit           e_ldr;
  } vec_t;

  vec_t vecs[$];
  logic [L+D-1:0] exp_q[$];

  function automatic logic [W-1:0] mk(int tgt, int op, int dp);
    logic [L-1:0] t;
    logic [C-1:0] o;
    logic [D-1:0] d;
    t = L'(tgt);
    o = C'(op);
    d = D'(dp);
    return {t, o, d};
  endfunction

  function automatic void add(string tag, bit s, bit c, bit v, int a, logic [W-1:0] d,
                              int e_pc, int e_pd, bit e_b, bit e_h, bit e_r);
    vec_t r;
    r.tag = tag; r.start = s; r.cres = c; r.ldv = v;
    r.lda = L'(a); r.ldd = d;
    r.e_pc = L'(e_pc); r.e_pd = D'(e_pd);
    r.e_busy = e_b; r.e_halted = e_h; r.e_ldr = e_r;
    vecs.push_back(r);
  endfunction

  // scoreboard compare
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(bit s, bit c, bit v, logic [L-1:0] a, logic [W-1:0] d);
    start        = s;
    bus.cres     = c;
    bus.ld_valid = v;
    bus.ld_addr  = a;
    bus.ld_data  = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(string tag);
    check({tag, ".pc"},     32'(pc), 32'd0);
    check({tag, ".pd"},     32'(bus.pd_ctrl), 32'd0);
    check({tag, ".busy"},   32'(busy), 32'd0);
    check({tag, ".halted"}, 32'(halted), 32'd0);
    check({tag, ".ldr"},    32'(bus.ld_ready), 32'd1);
    check({tag, ".state"},  32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Program mem0 BRC->14 (dp 09), mem1 HALT (07), mem14/15 NEXT (0C/0D);
  // cres=1 only on the first instruction: 0,14,15,wrap to 0,1,halt.
  task automatic run_prog(string tag);
    int n;
    exp_q.push_back({4'd0,  5'h09});
    exp_q.push_back({4'd14, 5'h0C});
    exp_q.push_back({4'd15, 5'h0D});
    exp_q.push_back({4'd0,  5'h09});
    exp_q.push_back({4'd1,  5'h07});
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    next_cycle();
    start = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      bus.cres = (n == 0);
      @(negedge clk);
      check($sformatf("%s.step%0d", tag, n), 32'({pc, bus.pd_ctrl}), 32'(exp_q.pop_front()));
      next_cycle();
      n++;
    end
    bus.cres = 1'b0;
    @(negedge clk);
    check({tag, ".halted"}, 32'(halted), 32'd1);
    check({tag, ".halt_pc"}, 32'(pc), 32'd1);
    check({tag, ".halt_pd"}, 32'(bus.pd_ctrl), 32'd0);
    next_cycle();
  endtask

  initial begin
    // straight-line program with mid-run load stall
    add("ld0",        0, 0, 1, 0, mk(0, 0, 5'h01),  0, 5'h00, 0, 0, 1);
    add("ld1",        0, 0, 1, 1, mk(0, 0, 5'h02),  0, 5'h00, 0, 0, 1);
    add("ld2",        0, 0, 1, 2, mk(0, 0, 5'h04),  0, 5'h00, 0, 0, 1);
    add("ld3_start",  1, 0, 1, 3, mk(0, 3, 5'h18),  0, 5'h00, 0, 0, 1);
    add("idle_stay",  0, 0, 0, 0, '0,               0, 5'h00, 0, 0, 1);
    add("start",      1, 0, 0, 0, '0,               0, 5'h00, 0, 0, 1);
    add("run0",       0, 0, 0, 0, '0,               0, 5'h01, 1, 0, 0);
    add("run1_stall", 1, 0, 1, 2, mk(0, 3, 5'h1F),  1, 5'h02, 1, 0, 0);
    add("run2",       0, 0, 0, 0, '0,               2, 5'h04, 1, 0, 0);
    add("run3_halt",  0, 0, 0, 0, '0,               3, 5'h18, 1, 0, 0);
    add("halted3",    0, 0, 0, 0, '0,               3, 5'h00, 0, 1, 1);
    // load + start in HALT: write happens, stays halted
    add("h_ld_start", 1, 0, 1, 0, mk(5, 2, 5'h03),  3, 5'h00, 0, 1, 1);
    add("h_hold",     0, 0, 0, 0, '0,               3, 5'h00, 0, 1, 1);
    add("ld5",        0, 0, 1, 5, mk(0, 3, 5'h00),  3, 5'h00, 0, 1, 1);
    add("ld1_halt",   0, 0, 1, 1, mk(0, 3, 5'h07),  3, 5'h00, 0, 1, 1);
    // branch taken, then not taken
    add("b_start1",   1, 0, 0, 0, '0,               3, 5'h00, 0, 1, 1);
    add("brc_taken",  0, 1, 0, 0, '0,               0, 5'h03, 1, 0, 0);
    add("at5",        0, 0, 0, 0, '0,               5, 5'h00, 1, 0, 0);
    add("halted5",    0, 0, 0, 0, '0,               5, 5'h00, 0, 1, 1);
    add("b_start2",   1, 0, 0, 0, '0,               5, 5'h00, 0, 1, 1);
    add("brc_not",    0, 0, 0, 0, '0,               0, 5'h03, 1, 0, 0);
    add("at1",        0, 0, 0, 0, '0,               1, 5'h07, 1, 0, 0);
    add("halted1",    0, 0, 0, 0, '0,               1, 5'h00, 0, 1, 1);
    // wrap program 0 -> 14 -> 15 -> 0 -> 1
    add("ld0_brc14",  0, 0, 1, 0,  mk(14, 2, 5'h09), 1, 5'h00, 0, 1, 1);
    add("ld14",       0, 0, 1, 14, mk(0, 0, 5'h0C),  1, 5'h00, 0, 1, 1);
    add("ld15",       0, 0, 1, 15, mk(0, 0, 5'h0D),  1, 5'h00, 0, 1, 1);
    add("w_start",    1, 0, 0, 0,  '0,               1, 5'h00, 0, 1, 1);
    add("w0",         0, 1, 0, 0,  '0,               0, 5'h09, 1, 0, 0);
    add("w14_start",  1, 0, 0, 0,  '0,              14, 5'h0C, 1, 0, 0);
    add("w15",        0, 0, 0, 0,  '0,              15, 5'h0D, 1, 0, 0);
    add("w_wrap0",    0, 0, 0, 0,  '0,               0, 5'h09, 1, 0, 0);
    add("w1",         0, 0, 0, 0,  '0,               1, 5'h07, 1, 0, 0);
    add("w_halted",   0, 0, 0, 0,  '0,               1, 5'h00, 0, 1, 1);

    // reset block
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].cres, vecs[i].ldv, vecs[i].lda, vecs[i].ldd);
      @(negedge clk);
      check({vecs[i].tag, ".pc"},     32'(pc),           32'(vecs[i].e_pc));
      check({vecs[i].tag, ".pd"},     32'(bus.pd_ctrl),  32'(vecs[i].e_pd));
      check({vecs[i].tag, ".busy"},   32'(busy),         32'(vecs[i].e_busy));
      check({vecs[i].tag, ".halted"}, 32'(halted),       32'(vecs[i].e_halted));
      check({vecs[i].tag, ".ldr"},    32'(bus.ld_ready), 32'(vecs[i].e_ldr));
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);

    // reset mid-run, with a colliding load and start that must be dropped
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    next_cycle();
    @(negedge clk);
    check("midrun.pc", 32'(pc), 32'd14);
    check("midrun.busy", 32'(busy), 32'd1);
    next_cycle();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 4'd14, mk(0, 3, 5'h1F));
    repeat (2) @(posedge clk);
    #1;
    check_idle("rst_midrun");
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    next_cycle();
    check_idle("after_rst");

    // same program from IDLE, then restart from HALT
    run_prog("run_a");
    run_prog("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
